// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
// Bundles the execute -> writeback handshake and the register-file write and
// retirement outputs of writeback_stage.
//   master : execute side (drives instruction fields, observes outputs)
//   slave  : writeback_stage
// Signal groups:
//   handshake   exValidIn / wbReadyOut / killIn
//   instruction currentRipIn, opcode fields, results, destinations
//   regfile     regWriteEnOut / regWriteAddrOut / regWriteDataOut
//   retirement  retireOut / retiredRipOut / retireCountOut / haltOut
// ---------------------------------------------------------------------------
interface writeback_stage_if;
    logic          exValidIn;
    logic          wbReadyOut;
    logic          killIn;
    logic [0:31]   currentRipIn;
    logic [0:7]    opcodeIn;
    logic [0:31]   opcodeLengthIn;
    logic [0:31]   hasExtendedOpcodeIn;
    logic [0:2]    extendedOpcodeIn;
    logic [0:63]   aluResultIn;
    logic [0:63]   aluResultSpecialIn;
    logic [0:3]    destRegIn;
    logic [0:3]    destRegSpecialIn;
    logic          destRegSpecialValidIn;
    logic          regWriteEnOut;
    logic [0:3]    regWriteAddrOut;
    logic [0:63]   regWriteDataOut;
    logic          retireOut;
    logic [0:31]   retiredRipOut;
    logic [0:31]   retireCountOut;
    logic          haltOut;

    modport master (
        output exValidIn, killIn, currentRipIn, opcodeIn, opcodeLengthIn,
               hasExtendedOpcodeIn, extendedOpcodeIn, aluResultIn,
               aluResultSpecialIn, destRegIn, destRegSpecialIn,
               destRegSpecialValidIn,
        input  wbReadyOut, regWriteEnOut, regWriteAddrOut, regWriteDataOut,
               retireOut, retiredRipOut, retireCountOut, haltOut
    );

    modport slave (
        input  exValidIn, killIn, currentRipIn, opcodeIn, opcodeLengthIn,
               hasExtendedOpcodeIn, extendedOpcodeIn, aluResultIn,
               aluResultSpecialIn, destRegIn, destRegSpecialIn,
               destRegSpecialValidIn,
        output wbReadyOut, regWriteEnOut, regWriteAddrOut, regWriteDataOut,
               retireOut, retiredRipOut, retireCountOut, haltOut
    );
endinterface

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Accepts one executed instruction per valid/ready
// handshake, writes the primary result to the register file, then the
// special (RDX) result one cycle later when present. Compare-only
// instructions retire without writing. A kill (return) retires and parks the
// core in HALT until reset.
// Ports:
//   clk    core clock, rising edge
//   reset  asynchronous, active-high
//   wb     writeback_stage_if.slave (handshake, instruction, regfile write,
//          retirement status)
// ---------------------------------------------------------------------------
module writeback_stage (
    input  logic              clk,
    input  logic              reset,
    writeback_stage_if.slave  wb
);

    localparam logic [1:0] S_IDLE          = 2'd0;
    localparam logic [1:0] S_WRITE_MAIN    = 2'd1;
    localparam logic [1:0] S_WRITE_SPECIAL = 2'd2;
    localparam logic [1:0] S_HALT          = 2'd3;

    logic [1:0]  r_state;
    logic        r_spec_valid;
    logic [0:3]  r_spec_addr;
    logic [0:63] r_spec_data;
    logic [0:31] r_pend_rip;

    logic        r_wr_en;
    logic [0:3]  r_wr_addr;
    logic [0:63] r_wr_data;
    logic        r_retire;
    logic [0:31] r_retired_rip;
    logic [0:31] r_retire_count;
    logic        r_halt;

    logic        w_ready;
    logic        w_accept;
    logic        w_is_cmp;
    logic        w_retire_set;
    logic [0:31] w_retire_rip;

    // A new instruction can enter while idle, or overlap the final cycle of a
    // main-only write. Held low during reset so nothing is taken mid-reset.
    assign w_ready  = !reset &&
                      ((r_state == S_IDLE) ||
                       ((r_state == S_WRITE_MAIN) && !r_spec_valid));
    assign w_accept = wb.exValidIn && w_ready;

    // Compare-only forms: CMP r/m,r / CMP r,r/m / CMP eAX,imm and
    // group-1 immediate with /7.
    assign w_is_cmp = (wb.opcodeLengthIn == 32'd1) &&
                      ((wb.opcodeIn == 8'h39) || (wb.opcodeIn == 8'h3B) ||
                       (wb.opcodeIn == 8'h3D) ||
                       (((wb.opcodeIn == 8'h81) || (wb.opcodeIn == 8'h83)) &&
                        (wb.hasExtendedOpcodeIn == 32'd1) &&
                        (wb.extendedOpcodeIn == 3'b111)));

    // Retirement happens in the last write cycle of an instruction: either
    // straight after accept (no special write, or a kill) or on the
    // WRITE_MAIN -> WRITE_SPECIAL transition. The two cases are exclusive
    // because no accept is possible while a special write is pending.
    // NOTE: every always_comb output gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        w_retire_set = 1'b0;
        w_retire_rip = r_pend_rip;
        if (w_accept && (wb.killIn || !wb.destRegSpecialValidIn)) begin
            w_retire_set = 1'b1;
            w_retire_rip = wb.currentRipIn;
        end else if ((r_state == S_WRITE_MAIN) && r_spec_valid) begin
            w_retire_set = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the pending special-write latch is reset along with the control
    // state, which is what discards a special write interrupted by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_spec_valid <= 1'b0;
            r_spec_addr  <= '0;
            r_spec_data  <= '0;
            r_pend_rip   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_halt       <= 1'b0;
        end else if (w_accept) begin
            if (wb.killIn) begin
                r_state <= S_HALT;
                r_wr_en <= 1'b0;
                r_halt  <= 1'b1;
            end else begin
                r_state      <= S_WRITE_MAIN;
                r_wr_en      <= !w_is_cmp;
                r_wr_addr    <= wb.destRegIn;
                r_wr_data    <= wb.aluResultIn;
                r_spec_valid <= wb.destRegSpecialValidIn;
                r_spec_addr  <= wb.destRegSpecialIn;
                r_spec_data  <= wb.aluResultSpecialIn;
                r_pend_rip   <= wb.currentRipIn;
            end
        end else begin
            case (r_state)
                S_WRITE_MAIN: begin
                    if (r_spec_valid) begin
                        // Special write lands after the main write, so it
                        // wins when both target the same register.
                        r_state      <= S_WRITE_SPECIAL;
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= r_spec_addr;
                        r_wr_data    <= r_spec_data;
                        r_spec_valid <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_wr_en <= 1'b0;
                    end
                end
                S_WRITE_SPECIAL: begin
                    r_state <= S_IDLE;
                    r_wr_en <= 1'b0;
                end
                S_HALT: begin
                    r_wr_en <= 1'b0;
                end
                default: begin
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire       <= 1'b0;
            r_retired_rip  <= '0;
            r_retire_count <= '0;
        end else begin
            r_retire <= w_retire_set;
            if (w_retire_set) begin
                r_retired_rip  <= w_retire_rip;
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign wb.wbReadyOut      = w_ready;
    assign wb.regWriteEnOut   = r_wr_en;
    assign wb.regWriteAddrOut = r_wr_addr;
    assign wb.regWriteDataOut = r_wr_data;
    assign wb.retireOut       = r_retire;
    assign wb.retiredRipOut   = r_retired_rip;
    assign wb.retireCountOut  = r_retire_count;
    assign wb.haltOut         = r_halt;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Directed bench for writeback_stage. Expected register writes and expected
// retirements are queued when an instruction is driven and compared as the
// DUT presents them; directed checks cover ready, halt and counter values.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    typedef struct packed {
        logic [0:3]  addr;
        logic [0:63] data;
    } wr_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wr_t         wr_q[$];
    logic [31:0] ret_q[$];
    logic [31:0] exp_count;

    writeback_stage_if wb_if ();

    writeback_stage dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_cmp(input logic [7:0] op, input logic [31:0] len,
                                  input logic [31:0] hasx, input logic [2:0] x);
        bit plain_cmp;
        bit grp1_cmp;
        plain_cmp = (op == 8'h39) || (op == 8'h3B) || (op == 8'h3D);
        grp1_cmp  = ((op == 8'h81) || (op == 8'h83)) && (hasx == 32'd1) && (x == 3'd7);
        return (len == 32'd1) && (plain_cmp || grp1_cmp);
    endfunction

    task automatic idle_in();
        wb_if.exValidIn             = 1'b0;
        wb_if.killIn                = 1'b0;
        wb_if.currentRipIn          = '0;
        wb_if.opcodeIn              = '0;
        wb_if.opcodeLengthIn        = '0;
        wb_if.hasExtendedOpcodeIn   = '0;
        wb_if.extendedOpcodeIn      = '0;
        wb_if.aluResultIn           = '0;
        wb_if.aluResultSpecialIn    = '0;
        wb_if.destRegIn             = '0;
        wb_if.destRegSpecialIn      = '0;
        wb_if.destRegSpecialValidIn = 1'b0;
    endtask

    // Drive one instruction and, when push is set, record what it must
    // produce. Only call with push=1 when the DUT is expected to accept it.
    task automatic drive(input bit push, input bit kill, input logic [31:0] rip,
                         input logic [7:0] op, input logic [31:0] len,
                         input logic [31:0] hasx, input logic [2:0] x,
                         input logic [3:0] dst, input logic [63:0] res,
                         input bit spv, input logic [3:0] sdst,
                         input logic [63:0] sres);
        wb_if.exValidIn             = 1'b1;
        wb_if.killIn                = kill;
        wb_if.currentRipIn          = rip;
        wb_if.opcodeIn              = op;
        wb_if.opcodeLengthIn        = len;
        wb_if.hasExtendedOpcodeIn   = hasx;
        wb_if.extendedOpcodeIn      = x;
        wb_if.aluResultIn           = res;
        wb_if.aluResultSpecialIn    = sres;
        wb_if.destRegIn             = dst;
        wb_if.destRegSpecialIn      = sdst;
        wb_if.destRegSpecialValidIn = spv;
        if (push) begin
            if (!kill && !is_cmp(op, len, hasx, x)) wr_q.push_back('{dst, res});
            if (!kill && spv) wr_q.push_back('{sdst, sres});
            ret_q.push_back(rip);
        end
    endtask

    // Advance one clock and score whatever the DUT presents in the new cycle.
    task automatic tick();
        wr_t         w;
        logic [31:0] r;
        @(posedge clk);
        #1;
        if (wr_q.size() != 0 && wb_if.regWriteEnOut) begin
            w = wr_q.pop_front();
            check("wr_addr", 64'(wb_if.regWriteAddrOut), 64'(w.addr));
            check("wr_data", 64'(wb_if.regWriteDataOut), 64'(w.data));
        end else if (wr_q.size() == 0) begin
            check("spurious_write", 64'(wb_if.regWriteEnOut), 64'(0));
        end
        if (ret_q.size() != 0 && wb_if.retireOut) begin
            r = ret_q.pop_front();
            exp_count = exp_count + 32'd1;
            check("retired_rip", 64'(wb_if.retiredRipOut), 64'(r));
        end else if (ret_q.size() == 0) begin
            check("spurious_retire", 64'(wb_if.retireOut), 64'(0));
        end
        check("retire_count", 64'(wb_if.retireCountOut), 64'(exp_count));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    64'(wb_if.regWriteEnOut),   64'(0));
        check({tag, "_addr"},  64'(wb_if.regWriteAddrOut), 64'(0));
        check({tag, "_data"},  64'(wb_if.regWriteDataOut), 64'(0));
        check({tag, "_ret"},   64'(wb_if.retireOut),       64'(0));
        check({tag, "_rip"},   64'(wb_if.retiredRipOut),   64'(0));
        check({tag, "_count"}, 64'(wb_if.retireCountOut),  64'(0));
        check({tag, "_halt"},  64'(wb_if.haltOut),         64'(0));
        check({tag, "_ready"}, 64'(wb_if.wbReadyOut),      64'(0));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 0;
        reset     = 1'b1;
        idle_in();

        // Reset state.
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        #1;
        check("ready_idle", 64'(wb_if.wbReadyOut), 64'(1));

        // ADD: single write, retire in the write cycle.
        drive(1, 0, 32'h100, 8'h01, 1, 0, 0, 4'd3, 64'h5, 0, 4'd0, 64'h0);
        tick();
        check("add_en",     64'(wb_if.regWriteEnOut), 64'(1));
        check("add_retire", 64'(wb_if.retireOut),     64'(1));
        idle_in();
        tick();
        check("add_en_drop", 64'(wb_if.regWriteEnOut), 64'(0));
        check("add_count",   64'(wb_if.retireCountOut), 64'(1));

        // MUL F7 /4: main then special write, retire on the second.
        drive(1, 0, 32'h200, 8'hF7, 1, 1, 3'd4, 4'd0, 64'hAA, 1, 4'd2, 64'h1);
        tick();
        check("mul_ready_main", 64'(wb_if.wbReadyOut), 64'(0));
        check("mul_no_retire",  64'(wb_if.retireOut),  64'(0));
        idle_in();
        tick();
        check("mul_ready_spec", 64'(wb_if.wbReadyOut), 64'(0));
        check("mul_retire",     64'(wb_if.retireOut),  64'(1));
        tick();
        check("mul_idle_ready", 64'(wb_if.wbReadyOut),    64'(1));
        check("mul_idle_en",    64'(wb_if.regWriteEnOut), 64'(0));

        // CMP 83/7 then CMP 3B back to back: no writes, two retirements.
        drive(1, 0, 32'h300, 8'h83, 1, 1, 3'd7, 4'd5, 64'h99, 0, 4'd0, 64'h0);
        tick();
        check("cmp1_en", 64'(wb_if.regWriteEnOut), 64'(0));
        drive(1, 0, 32'h304, 8'h3B, 1, 0, 0, 4'd6, 64'h98, 0, 4'd0, 64'h0);
        tick();
        check("cmp2_en", 64'(wb_if.regWriteEnOut), 64'(0));
        // Near misses of the decode still write: 83/6 and 3B with length 2.
        drive(1, 0, 32'h308, 8'h83, 1, 1, 3'd6, 4'd7, 64'h77, 0, 4'd0, 64'h0);
        tick();
        drive(1, 0, 32'h30C, 8'h3B, 2, 0, 0, 4'd8, 64'h78, 0, 4'd0, 64'h0);
        tick();
        idle_in();
        tick();
        check("cmp_count", 64'(wb_if.retireCountOut), 64'(6));

        // Three back-to-back ADDs with valid held high.
        for (int i = 1; i <= 3; i++) begin
            check("b2b_ready", 64'(wb_if.wbReadyOut), 64'(1));
            drive(1, 0, 32'h400 + 32'(i), 8'h01, 1, 0, 0, 4'(i), 64'(16 * i), 0, 4'd0, 64'h0);
            tick();
            check("b2b_en", 64'(wb_if.regWriteEnOut), 64'(1));
        end
        idle_in();
        tick();

        // Counter wrap: preload to all-ones, then one retirement.
        force dut.r_retire_count = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        tick();
        release dut.r_retire_count;
        drive(1, 0, 32'h500, 8'h01, 1, 0, 0, 4'd4, 64'h44, 0, 4'd0, 64'h0);
        tick();
        check("wrap_count", 64'(wb_if.retireCountOut), 64'(0));
        idle_in();
        tick();

        // Reset during WRITE_MAIN of a MUL: special write must never appear.
        wr_q.push_back('{4'd6, 64'h66});
        drive(0, 0, 32'h600, 8'hF7, 1, 1, 3'd5, 4'd6, 64'h66, 1, 4'd9, 64'h9);
        tick();
        idle_in();
        #2;
        reset = 1'b1;
        exp_count = 0;
        #1;
        check_all_zero("midreset");
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_reset_en", 64'(wb_if.regWriteEnOut), 64'(0));

        // ADD then kill: ADD writes, then halt with retire and no write.
        drive(1, 0, 32'h700, 8'h01, 1, 0, 0, 4'd8, 64'h88, 0, 4'd0, 64'h0);
        tick();
        check("pre_kill_halt", 64'(wb_if.haltOut), 64'(0));
        drive(1, 1, 32'h704, 8'hC3, 1, 0, 0, 4'd1, 64'h1, 0, 4'd0, 64'h0);
        tick();
        check("kill_halt",   64'(wb_if.haltOut),       64'(1));
        check("kill_retire", 64'(wb_if.retireOut),     64'(1));
        check("kill_rip",    64'(wb_if.retiredRipOut), 64'(32'h704));
        check("kill_en",     64'(wb_if.regWriteEnOut), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h800 + 32'(i), 8'h01, 1, 0, 0, 4'd2, 64'h22, 0, 4'd0, 64'h0);
            tick();
            check("halt_ready", 64'(wb_if.wbReadyOut), 64'(0));
            check("halt_held",  64'(wb_if.haltOut),    64'(1));
            idle_in();
            tick();
        end

        check("wr_q_drained",  64'(wr_q.size()),  64'(0));
        check("ret_q_drained", 64'(ret_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
